// File: rtl/qtcore_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qtcore_seq_pkg
//  Description : Shared state encoding and default sizing for the qtcore
//                scan-chain sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package qtcore_seq_pkg;

    // Default scan-chain length of the attached core, in bytes
    localparam int c_default_chain_bytes = 20;
    // Default maximum number of RUN cycles before the run is aborted
    localparam int c_default_run_timeout = 4096;

    // Sequencer states; exactly one is active per cycle
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_RUN   = 3'd3,
        S_READ  = 3'd4,
        S_FIN   = 3'd5
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/qtcore_seq_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : qtcore_seq_shifter
//  Description : 8-bit MSB-first serialiser/deserialiser with a 3-bit bit
//                counter. Used to emit program bytes and to assemble
//                readback bytes from the core scan chain.
//  Revision    : 1.0 - initial release
// ============================================================================
module qtcore_seq_shifter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       shift_en,
    input  logic       serial_in,
    output logic [7:0] shift_reg,
    output logic       bit_last
);

    logic [7:0] r_sr;
    logic [2:0] r_bit_cnt;

    // Load clears the bit counter; each shift moves the register left by one,
    // and the counter returns to zero explicitly after the eighth bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr      <= 8'h00;
            r_bit_cnt <= 3'd0;
        end else if (load) begin
            r_sr      <= load_data;
            r_bit_cnt <= 3'd0;
        end else if (shift_en) begin
            r_sr      <= {r_sr[6:0], serial_in};
            r_bit_cnt <= (r_bit_cnt == 3'd7) ? 3'd0 : r_bit_cnt + 3'd1;
        end
    end

    assign shift_reg = r_sr;
    assign bit_last  = (r_bit_cnt == 3'd7);

endmodule
`default_nettype wire

// File: rtl/qtcore_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : qtcore_sequencer
//  Description : Loads a program into a qtcore scan chain byte by byte, runs
//                the core until halt or timeout, and optionally reads the
//                chain back. Readback is built when QTCORE_SEQ_READBACK_EN
//                is defined; otherwise dout/dout_valid are tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module qtcore_sequencer
    import qtcore_seq_pkg::*;
#(
    parameter int CHAIN_BYTES = c_default_chain_bytes,
    parameter int RUN_TIMEOUT = c_default_run_timeout
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       scan_enable,
    output logic       scan_in,
    input  logic       scan_out,
    output logic       proc_en,
    input  logic       halt,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [7:0] dout,
    output logic       dout_valid
);

    localparam int c_BYTE_W = $clog2(CHAIN_BYTES + 1);
    localparam int c_RUN_W  = (RUN_TIMEOUT > 1) ? $clog2(RUN_TIMEOUT) : 1;

    localparam logic [c_BYTE_W-1:0] c_chain_bytes = c_BYTE_W'(CHAIN_BYTES);
    localparam logic [c_BYTE_W-1:0] c_last_byte   = c_BYTE_W'(CHAIN_BYTES - 1);
    localparam logic [c_RUN_W-1:0]  c_run_last    = c_RUN_W'(RUN_TIMEOUT - 1);

`ifdef QTCORE_SEQ_READBACK_EN
    localparam seq_state_t c_after_run = S_READ;
`else
    localparam seq_state_t c_after_run = S_FIN;
`endif

    seq_state_t          r_state;
    seq_state_t          w_next_state;
    logic [c_BYTE_W-1:0] r_byte_cnt;
    logic [c_RUN_W-1:0]  r_run_cnt;
    logic                r_timeout;
    logic                w_handshake;
    logic                w_run_abort;
    logic                w_read_entry;
    logic                w_bit_last;
    logic [7:0]          w_sr;
    logic                w_serial_in;

    // State register, phase counters and the sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_byte_cnt <= '0;
            r_run_cnt  <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (r_state == S_IDLE && start) begin
                r_byte_cnt <= '0;
            end else if (w_handshake) begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end else if (w_read_entry) begin
                r_byte_cnt <= '0;
            end else if (r_state == S_READ && w_bit_last) begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end

            // Held at zero outside RUN so each run starts counting from 0;
            // saturates at the abort value instead of wrapping.
            if (r_state != S_RUN) begin
                r_run_cnt <= '0;
            end else if (r_run_cnt != c_run_last) begin
                r_run_cnt <= r_run_cnt + 1'b1;
            end

            if (r_state == S_IDLE && start) begin
                r_timeout <= 1'b0;
            end else if (w_run_abort) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // Next-state decode and per-state control outputs
    always_comb begin
        w_next_state = r_state;
        din_ready    = 1'b0;
        scan_enable  = 1'b0;
        proc_en      = 1'b0;
        done         = 1'b0;
        w_handshake  = 1'b0;
        w_run_abort  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_LOAD;
            end
            S_LOAD: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    w_handshake  = 1'b1;
                    w_next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                scan_enable = 1'b1;
                if (w_bit_last) begin
                    w_next_state = (r_byte_cnt < c_chain_bytes) ? S_LOAD : S_RUN;
                end
            end
            S_RUN: begin
                proc_en = 1'b1;
                if (halt) begin
                    w_next_state = c_after_run;
                end else if (r_run_cnt == c_run_last) begin
                    w_run_abort  = 1'b1;
                    w_next_state = c_after_run;
                end
            end
`ifdef QTCORE_SEQ_READBACK_EN
            S_READ: begin
                scan_enable = 1'b1;
                if (w_bit_last && r_byte_cnt == c_last_byte) w_next_state = S_FIN;
            end
`endif
            S_FIN: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_read_entry = (r_state == S_RUN) && (w_next_state == S_READ);
    assign busy         = (r_state != S_IDLE);
    assign timeout      = r_timeout;
    // Program bits leave MSB first; READ drives zeros into the chain
    assign scan_in      = (r_state == S_SHIFT) & w_sr[7];

    qtcore_seq_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (w_handshake | w_read_entry),
        .load_data (w_handshake ? din : 8'h00),
        .shift_en  (scan_enable),
        .serial_in (w_serial_in),
        .shift_reg (w_sr),
        .bit_last  (w_bit_last)
    );

`ifdef QTCORE_SEQ_READBACK_EN
    logic [7:0] r_dout;
    logic       r_dout_valid;

    assign w_serial_in = scan_out;

    // Publish each assembled byte, including the bit arriving this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout       <= 8'h00;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= (r_state == S_READ) && w_bit_last;
            if ((r_state == S_READ) && w_bit_last) r_dout <= {w_sr[6:0], scan_out};
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
`else
    logic w_unused;

    assign w_serial_in = 1'b0;
    assign w_unused    = &{1'b0, w_sr[6:0], scan_out};
    assign dout        = 8'h00;
    assign dout_valid  = 1'b0;
`endif

endmodule
`default_nettype wire
